// File: rtl/mips16_mc_control.sv
//------------------------------------------------------------------------------
// Module      : mips16_mc_control
// Description : Multi-cycle control FSM for a 16-bit MIPS-like core. The
//               FETCH/DECODE/EXEC/MEM/WB/HALT sequencer drives the datapath
//               enables and mux selects. A per-request wait counter stops a
//               hung memory from locking up the core, and an optional counter
//               tracks retired instructions.
// Revision    : 1.0 - initial release
//
// Configuration macro:
//   MIPS16_MC_RETIRE_CNT_EN - when defined, instr_count counts retired
//                             instructions. When undefined, the counter logic
//                             is absent and instr_count is tied to 0.
//
// Ports:
//   clk          in   1  rising-edge clock
//   reset        in   1  synchronous active-low reset
//   opcode       in   3  instr[15:13] from the instruction register
//   zero         in   1  ALU zero flag (selects the beq branch)
//   mem_ack      in   1  memory completion strobe, used in FETCH/MEM only
//   state        out  3  FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=7
//   pc_we        out  1  program counter write enable
//   ir_we        out  1  instruction register write enable
//   reg_we       out  1  register file write enable
//   pc_src       out  2  00 pc+2, 01 branch target, 10 jump target
//   reg_dst      out  2  00 rt, 01 rd, 10 r7
//   mem_to_reg   out  2  00 ALU, 01 memory, 10 pc
//   alu_src      out  1  0 register, 1 immediate
//   alu_op       out  2  00 add, 01 sub, 10 funct, 11 slt
//   mem_req      out  1  memory request
//   mem_we       out  1  memory write
//   mem_sel      out  1  0 instruction, 1 data
//   bus_err      out  1  sticky memory-timeout flag
//   instr_count  out 16  retired-instruction count
//------------------------------------------------------------------------------
`default_nettype none

module mips16_mc_control #(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  opcode,
  input  logic        zero,
  input  logic        mem_ack,
  output logic [2:0]  state,
  output logic        pc_we,
  output logic        ir_we,
  output logic        reg_we,
  output logic [1:0]  pc_src,
  output logic [1:0]  reg_dst,
  output logic [1:0]  mem_to_reg,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel,
  output logic        bus_err,
  output logic [15:0] instr_count
);

  localparam logic [2:0] c_FETCH  = 3'd0;
  localparam logic [2:0] c_DECODE = 3'd1;
  localparam logic [2:0] c_EXEC   = 3'd2;
  localparam logic [2:0] c_MEM    = 3'd3;
  localparam logic [2:0] c_WB     = 3'd4;
  localparam logic [2:0] c_HALT   = 3'd7;

  localparam logic [2:0] c_OP_R    = 3'b000;
  localparam logic [2:0] c_OP_SLTI = 3'b001;
  localparam logic [2:0] c_OP_J    = 3'b010;
  localparam logic [2:0] c_OP_JAL  = 3'b011;
  localparam logic [2:0] c_OP_LW   = 3'b100;
  localparam logic [2:0] c_OP_SW   = 3'b101;
  localparam logic [2:0] c_OP_BEQ  = 3'b110;
  localparam logic [2:0] c_OP_ADDI = 3'b111;

  localparam logic [7:0] c_TIMEOUT = 8'(ACK_TIMEOUT);

  logic [2:0] state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [7:0] wait_q, wait_d;
  logic       bus_err_q, bus_err_d;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= c_FETCH;
      op_q      <= 3'b000;
      wait_q    <= 8'd0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Next-state logic. The wait counter only advances while a FETCH/MEM
  // request stays pending, so every other path leaves it at zero. That
  // clears it on entry to FETCH or MEM.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    wait_d    = 8'd0;
    bus_err_d = bus_err_q;
    case (state_q)
      c_FETCH: begin
        if (mem_ack) begin
          state_d = c_DECODE;
        end else if (wait_q == c_TIMEOUT) begin
          state_d   = c_HALT;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      c_DECODE: begin
        op_d    = opcode;
        state_d = c_EXEC;
      end
      c_EXEC: begin
        case (op_q)
          c_OP_R, c_OP_SLTI, c_OP_ADDI: state_d = c_WB;
          c_OP_LW, c_OP_SW:             state_d = c_MEM;
          default:                      state_d = c_FETCH;
        endcase
      end
      c_MEM: begin
        if (mem_ack) begin
          state_d = (op_q == c_OP_SW) ? c_FETCH : c_WB;
        end else if (wait_q == c_TIMEOUT) begin
          state_d   = c_HALT;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      c_WB:    state_d = c_FETCH;
      c_HALT:  state_d = c_HALT;
      default: state_d = c_FETCH;
    endcase
  end

  // Output decode
  always_comb begin
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    pc_src     = 2'b00;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_sel    = 1'b0;

    // ALU controls are held for the whole EXEC..WB span of an instruction
    if ((state_q == c_EXEC) || (state_q == c_MEM) || (state_q == c_WB)) begin
      case (op_q)
        c_OP_R:    alu_op = 2'b10;
        c_OP_SLTI: alu_op = 2'b11;
        c_OP_BEQ:  alu_op = 2'b01;
        default:   alu_op = 2'b00;
      endcase
      alu_src = (op_q == c_OP_SLTI) || (op_q == c_OP_ADDI) ||
                (op_q == c_OP_LW)   || (op_q == c_OP_SW);
    end

    case (state_q)
      c_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
        end
      end
      c_EXEC: begin
        case (op_q)
          c_OP_BEQ: begin
            pc_src = 2'b01;
            pc_we  = zero;
          end
          c_OP_J: begin
            pc_src = 2'b10;
            pc_we  = 1'b1;
          end
          c_OP_JAL: begin
            pc_src     = 2'b10;
            pc_we      = 1'b1;
            reg_we     = 1'b1;
            reg_dst    = 2'b10;
            mem_to_reg = 2'b10;
          end
          default: ;
        endcase
      end
      c_MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = (op_q == c_OP_SW);
      end
      c_WB: begin
        reg_we     = 1'b1;
        reg_dst    = (op_q == c_OP_R)  ? 2'b01 : 2'b00;
        mem_to_reg = (op_q == c_OP_LW) ? 2'b01 : 2'b00;
      end
      default: ;
    endcase

    // While reset is held low, nothing may be written or requested, even
    // in the cycle before the reset edge.
    if (!reset) begin
      pc_we   = 1'b0;
      ir_we   = 1'b0;
      reg_we  = 1'b0;
      mem_req = 1'b0;
      mem_we  = 1'b0;
      mem_sel = 1'b0;
    end
  end

  assign state   = state_q;
  assign bus_err = bus_err_q;

`ifdef MIPS16_MC_RETIRE_CNT_EN
  logic [15:0] retire_q;
  logic        w_retire;

  // An instruction retires when control returns to FETCH from its last stage
  assign w_retire = (state_d == c_FETCH) &&
                    ((state_q == c_EXEC) || (state_q == c_MEM) || (state_q == c_WB));

  always_ff @(posedge clk) begin
    if (!reset) begin
      retire_q <= 16'h0000;
    end else if (w_retire) begin
      retire_q <= retire_q + 16'h0001;
    end
  end

  assign instr_count = retire_q;
`else
  assign instr_count = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mips16_mc_control.sv
//------------------------------------------------------------------------------
// Module      : tb_mips16_mc_control
// Description : Directed self-checking bench for mips16_mc_control.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mips16_mc_control;

  logic        clk;
  logic        reset;
  logic [2:0]  opcode;
  logic        zero;
  logic        mem_ack;
  logic [2:0]  state;
  logic        pc_we, ir_we, reg_we;
  logic [1:0]  pc_src, reg_dst, mem_to_reg;
  logic        alu_src;
  logic [1:0]  alu_op;
  logic        mem_req, mem_we, mem_sel, bus_err;
  logic [15:0] instr_count;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_cnt = 16'h0000;

  mips16_mc_control #(.ACK_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ack(mem_ack),
    .state(state), .pc_we(pc_we), .ir_we(ir_we), .reg_we(reg_we),
    .pc_src(pc_src), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src(alu_src), .alu_op(alu_op), .mem_req(mem_req), .mem_we(mem_we),
    .mem_sel(mem_sel), .bus_err(bus_err), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are read 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic retire_exp();
`ifdef MIPS16_MC_RETIRE_CNT_EN
    exp_cnt = exp_cnt + 16'h0001;
`endif
  endtask

  // From FETCH: ack the fetch at once, present op in DECODE, end up in EXEC.
  // The opcode input is then scrambled to show the decoded value was latched.
  task automatic do_fetch(input logic [2:0] op);
    mem_ack = 1'b1;
    opcode  = op;
    tick();
    mem_ack = 1'b0;
    tick();
    opcode = ~op;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; mem_ack = 1'b0; zero = 1'b0; opcode = 3'b000;
    tick(); tick(); #1;
    checks++;
    if (state !== 3'd0) begin
      errors++; $display("FAIL reset_state: got %0d expected 0", state);
    end
    checks++;
    if ({pc_we, ir_we, reg_we, mem_req, mem_we, mem_sel} !== 6'b0) begin
      errors++; $display("FAIL reset_enables: got %b expected 000000",
                         {pc_we, ir_we, reg_we, mem_req, mem_we, mem_sel});
    end
    checks++;
    if ({bus_err, instr_count} !== 17'h0) begin
      errors++; $display("FAIL reset_err_cnt: got %h expected 0", {bus_err, instr_count});
    end
    reset = 1'b1; #1;
    checks++;
    if ({mem_req, mem_sel, mem_we} !== 3'b100) begin
      errors++; $display("FAIL reset_first_req: got %b expected 100", {mem_req, mem_sel, mem_we});
    end
  endtask

  task automatic test_add();
    mem_ack = 1'b1; #1;
    checks++;
    if ({ir_we, pc_we, pc_src} !== 4'b1100) begin
      errors++; $display("FAIL add_fetch: got %b expected 1100", {ir_we, pc_we, pc_src});
    end
    tick(); mem_ack = 1'b0; opcode = 3'b000; #1;
    checks++;
    if (state !== 3'd1 || {pc_we, ir_we, reg_we, mem_req} !== 4'b0) begin
      errors++; $display("FAIL add_decode: got state %0d en %b expected 1 0000",
                         state, {pc_we, ir_we, reg_we, mem_req});
    end
    tick(); opcode = 3'b111; #1;
    checks++;
    if (state !== 3'd2 || alu_op !== 2'b10 || alu_src !== 1'b0 || reg_we !== 1'b0) begin
      errors++; $display("FAIL add_exec: got state %0d alu_op %b alu_src %b reg_we %b expected 2 10 0 0",
                         state, alu_op, alu_src, reg_we);
    end
    tick();
    checks++;
    if (state !== 3'd4 || reg_we !== 1'b1 || reg_dst !== 2'b01 || mem_to_reg !== 2'b00 || alu_op !== 2'b10) begin
      errors++; $display("FAIL add_wb: got state %0d reg_we %b reg_dst %b m2r %b alu_op %b expected 4 1 01 00 10",
                         state, reg_we, reg_dst, mem_to_reg, alu_op);
    end
    tick(); retire_exp();
    checks++;
    if (state !== 3'd0 || instr_count !== exp_cnt) begin
      errors++; $display("FAIL add_retire: got state %0d count %0d expected 0 %0d", state, instr_count, exp_cnt);
    end
  endtask

  task automatic test_lw();
    do_fetch(3'b100);
    checks++;
    if (state !== 3'd2 || alu_src !== 1'b1 || alu_op !== 2'b00) begin
      errors++; $display("FAIL lw_exec: got state %0d alu_src %b alu_op %b expected 2 1 00", state, alu_src, alu_op);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      mem_ack = (i == 3); #1;
      checks++;
      if (state !== 3'd3 || {mem_req, mem_sel, mem_we} !== 3'b110) begin
        errors++; $display("FAIL lw_mem_wait%0d: got state %0d req/sel/we %b expected 3 110",
                           i, state, {mem_req, mem_sel, mem_we});
      end
      tick();
    end
    mem_ack = 1'b0; #1;
    checks++;
    if (state !== 3'd4 || mem_to_reg !== 2'b01 || reg_we !== 1'b1 || reg_dst !== 2'b00) begin
      errors++; $display("FAIL lw_wb: got state %0d m2r %b reg_we %b reg_dst %b expected 4 01 1 00",
                         state, mem_to_reg, reg_we, reg_dst);
    end
    tick(); retire_exp();
    checks++;
    if (state !== 3'd0 || instr_count !== exp_cnt) begin
      errors++; $display("FAIL lw_retire: got state %0d count %0d expected 0 %0d", state, instr_count, exp_cnt);
    end
  endtask

  task automatic test_ack_ignored();
    mem_ack = 1'b1; opcode = 3'b111;
    tick(); #1;
    checks++;
    if (state !== 3'd1 || {ir_we, pc_we, mem_req} !== 3'b000) begin
      errors++; $display("FAIL ign_decode: got state %0d en %b expected 1 000", state, {ir_we, pc_we, mem_req});
    end
    tick(); #1;
    checks++;
    if (state !== 3'd2 || pc_we !== 1'b0 || alu_src !== 1'b1) begin
      errors++; $display("FAIL ign_exec: got state %0d pc_we %b alu_src %b expected 2 0 1", state, pc_we, alu_src);
    end
    tick(); #1;
    checks++;
    if (state !== 3'd4 || reg_dst !== 2'b00) begin
      errors++; $display("FAIL ign_wb: got state %0d reg_dst %b expected 4 00", state, reg_dst);
    end
    mem_ack = 1'b0;
    tick(); retire_exp();
  endtask

  task automatic test_beq();
    do_fetch(3'b110);
    zero = 1'b1; #1;
    checks++;
    if ({pc_we, pc_src, alu_op} !== 5'b10101) begin
      errors++; $display("FAIL beq_taken: got pc_we/pc_src/alu_op %b expected 10101", {pc_we, pc_src, alu_op});
    end
    tick(); retire_exp(); zero = 1'b0;
    checks++;
    if (state !== 3'd0) begin
      errors++; $display("FAIL beq_taken_ret: got %0d expected 0", state);
    end
    do_fetch(3'b110);
    zero = 1'b0; #1;
    checks++;
    if ({pc_we, pc_src} !== 3'b001) begin
      errors++; $display("FAIL beq_not_taken: got pc_we/pc_src %b expected 001", {pc_we, pc_src});
    end
    tick(); retire_exp();
    checks++;
    if (state !== 3'd0 || instr_count !== exp_cnt) begin
      errors++; $display("FAIL beq_ret: got state %0d count %0d expected 0 %0d", state, instr_count, exp_cnt);
    end
  endtask

  task automatic test_jumps();
    do_fetch(3'b011);
    checks++;
    if ({pc_we, pc_src, reg_we, reg_dst, mem_to_reg} !== 8'b1_10_1_10_10) begin
      errors++; $display("FAIL jal_exec: got %b expected 11011010",
                         {pc_we, pc_src, reg_we, reg_dst, mem_to_reg});
    end
    tick(); retire_exp();
    do_fetch(3'b010);
    checks++;
    if ({pc_we, pc_src, reg_we} !== 4'b1100) begin
      errors++; $display("FAIL j_exec: got %b expected 1100", {pc_we, pc_src, reg_we});
    end
    tick(); retire_exp();
    checks++;
    if (state !== 3'd0 || instr_count !== exp_cnt) begin
      errors++; $display("FAIL j_ret: got state %0d count %0d expected 0 %0d", state, instr_count, exp_cnt);
    end
  endtask

  task automatic test_slti();
    do_fetch(3'b001);
    checks++;
    if ({alu_op, alu_src} !== 3'b111) begin
      errors++; $display("FAIL slti_exec: got alu_op/alu_src %b expected 111", {alu_op, alu_src});
    end
    tick();
    checks++;
    if (state !== 3'd4 || {alu_op, alu_src, reg_dst} !== 5'b11100) begin
      errors++; $display("FAIL slti_wb: got state %0d %b expected 4 11100", state, {alu_op, alu_src, reg_dst});
    end
    tick(); retire_exp();
  endtask

  task automatic test_timeout();
    mem_ack = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    mem_ack = 1'b1; opcode = 3'b010; #1;
    checks++;
    if (state !== 3'd0 || ir_we !== 1'b1) begin
      errors++; $display("FAIL to_late_ack: got state %0d ir_we %b expected 0 1", state, ir_we);
    end
    tick(); mem_ack = 1'b0;
    checks++;
    if (state !== 3'd1) begin
      errors++; $display("FAIL to_late_decode: got %0d expected 1", state);
    end
    tick(); tick(); retire_exp();
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (state !== 3'd0 || mem_req !== 1'b1) begin
      errors++; $display("FAIL to_last_wait: got state %0d mem_req %b expected 0 1", state, mem_req);
    end
    tick();
    checks++;
    if (state !== 3'd7 || bus_err !== 1'b1 || {mem_req, pc_we, ir_we, reg_we} !== 4'b0) begin
      errors++; $display("FAIL to_halt: got state %0d bus_err %b en %b expected 7 1 0000",
                         state, bus_err, {mem_req, pc_we, ir_we, reg_we});
    end
    mem_ack = 1'b1; tick(); #1;
    checks++;
    if (state !== 3'd7 || bus_err !== 1'b1 || ir_we !== 1'b0) begin
      errors++; $display("FAIL to_sticky: got state %0d bus_err %b ir_we %b expected 7 1 0", state, bus_err, ir_we);
    end
    mem_ack = 1'b0; reset = 1'b0;
    tick(); exp_cnt = 16'h0000;
    checks++;
    if (state !== 3'd0 || bus_err !== 1'b0) begin
      errors++; $display("FAIL to_reset: got state %0d bus_err %b expected 0 0", state, bus_err);
    end
    reset = 1'b1;
  endtask

  task automatic test_sw_reset();
    do_fetch(3'b011);
    tick(); retire_exp();
    do_fetch(3'b101);
    tick();
    checks++;
    if (state !== 3'd3 || {mem_req, mem_sel, mem_we} !== 3'b111) begin
      errors++; $display("FAIL sw_mem: got state %0d %b expected 3 111", state, {mem_req, mem_sel, mem_we});
    end
    reset = 1'b0; #1;
    checks++;
    if ({mem_req, mem_we, mem_sel} !== 3'b000) begin
      errors++; $display("FAIL sw_reset_gate: got %b expected 000", {mem_req, mem_we, mem_sel});
    end
    tick(); exp_cnt = 16'h0000;
    checks++;
    if (state !== 3'd0 || mem_req !== 1'b0 || instr_count !== exp_cnt) begin
      errors++; $display("FAIL sw_reset: got state %0d mem_req %b count %0d expected 0 0 0",
                         state, mem_req, instr_count);
    end
    reset = 1'b1; #1;
    checks++;
    if (mem_req !== 1'b1) begin
      errors++; $display("FAIL sw_reset_release: got mem_req %b expected 1", mem_req);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_lw();
    test_ack_ignored();
    test_beq();
    test_jumps();
    test_slti();
    test_timeout();
    test_sw_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
